// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog_pkg.sv
// Shared types and helpers for the programmable glitch-free clock divider.
// Ratio is 2*(div+1); the state encoding is common to RTL and bench.
package gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  function automatic int ratio(input int div);
    return 2 * (div + 1);
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog_sync2.sv
// Two-flop synchronizer for the run request; adds 2 cycles of latency.
// Both flops clear on the asynchronous reset.
module gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog_sync2 (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_d};
    end
  end

  assign o_q = r_sync[1];

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog.sv
// Programmable 50%-duty divider, Z registered; ratio changes via load/ack on period boundaries.
// Z rises 1 edge after EN is seen; CLKDIV_SYNC_EN adds a 2-flop EN synchronizer (+2 cycles).
module gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog
  import gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog_pkg::*;
#(
  parameter int           W       = CNT_W,
  parameter logic [W-1:0] DIV_RST = '0
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_div,
  input  logic         i_div_ld,
  output logic         o_div_ack,
  output logic         o_busy,
  output logic         o_z
);

  logic w_en;

`ifdef CLKDIV_SYNC_EN
  gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog_sync2 u_en_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_en),
    .o_q     (w_en)
  );
`else
  assign w_en = i_en;
`endif

  state_t       r_state;
  logic [W-1:0] r_cnt;
  logic [W-1:0] r_active;
  logic [W-1:0] r_shadow;
  logic         r_pend;
  logic         r_z;
  logic         r_busy;
  logic         r_ack;

  logic w_cnt_end;
  logic w_apply;
  logic w_take;

  // Ratio updates only where no half-period is in flight, so HIGH and LOW always match.
  assign w_cnt_end = (r_cnt == r_active);
  assign w_apply   = (r_state == IDLE) || ((r_state == LOW) && w_cnt_end);
  assign w_take    = w_apply && (r_pend || i_div_ld);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_z      <= 1'b0;
      r_busy   <= 1'b0;
      r_ack    <= 1'b0;
      r_active <= DIV_RST;
      r_shadow <= DIV_RST;
      r_pend   <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      if (i_div_ld) begin
        r_shadow <= i_div;
        r_pend   <= 1'b1;
      end
      if (w_take) begin
        r_active <= i_div_ld ? i_div : r_shadow;
        r_pend   <= 1'b0;
        r_ack    <= 1'b1;
      end

      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_en) begin
            r_state <= HIGH;
            r_z     <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_z    <= 1'b0;
            r_busy <= 1'b0;
          end
        end
        HIGH: begin
          r_busy <= 1'b1;
          if (w_cnt_end) begin
            r_state <= LOW;
            r_z     <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        LOW: begin
          if (w_cnt_end) begin
            r_cnt <= '0;
            if (w_en) begin
              r_state <= HIGH;
              r_z     <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_z     <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_z       = r_z;
  assign o_busy    = r_busy;
  assign o_div_ack = r_ack;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog.sv
// Bench for the programmable clock divider: vector table, directed corner sequences,
// and random traffic against a period-position reference model.
module tb_gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog;
  import gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] div;
  logic       div_ld;
  logic       div_ack;
  logic       busy;
  logic       z;

  int n_chk  = 0;
  int n_fail = 0;

  gf180mcu_fd_sc_mcu9t5v0__clkdiv_prog #(.W(4), .DIV_RST(4'd0)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_en      (en),
    .i_div     (div),
    .i_div_ld  (div_ld),
    .o_div_ack (div_ack),
    .o_busy    (busy),
    .o_z       (z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position inside the current period, Z high for the first half.
  bit m_run, m_pend, m_ack, m_z, m_busy;
  int m_pos, m_act, m_sh;

  task automatic model_reset();
    m_run = 0; m_pend = 0; m_ack = 0; m_z = 0; m_busy = 0;
    m_pos = 0; m_act = 0; m_sh = 0;
  endtask

  task automatic model_step(input bit e, input bit l, input int d);
    int  h;
    bit  at_end;
    bit  boundary;
    h        = m_act + 1;
    at_end   = m_run && (m_pos == 2 * h - 1);
    boundary = !m_run || at_end;
    m_ack    = 0;
    if (boundary && (m_pend || l)) begin
      m_act  = l ? d : m_sh;
      m_pend = 0;
      m_ack  = 1;
      if (l) m_sh = d;
    end else if (l) begin
      m_sh   = d;
      m_pend = 1;
    end
    if (!m_run) begin
      if (e) begin m_run = 1; m_pos = 0; end
    end else if (at_end) begin
      if (e) m_pos = 0;
      else   m_run = 0;
    end else begin
      m_pos++;
    end
    m_z    = m_run && (m_pos < m_act + 1);
    m_busy = m_run;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input bit e, input bit l, input logic [3:0] d);
    en = e; div_ld = l; div = d;
    @(posedge clk);
    #1;
    model_step(e, l, int'(d));
    chk("model_z", z, m_z);
    chk("model_ack", div_ack, m_ack);
    chk("model_busy", busy, m_busy);
    div_ld = 1'b0;
  endtask

  typedef struct {
    bit       en;
    bit       ld;
    bit [3:0] div;
    bit       z;
    bit       ack;
    bit       busy;
  } vec_t;

  vec_t tbl[19];

  initial begin
    int rises[$];
    bit prev_z;
    int acks;
    bit ez, ea;
    bit ren;

    // Load 3 in IDLE, one full ratio-8 period, then EN dropped one cycle into HIGH.
    tbl[0]  = '{0, 1, 3, 0, 1, 0};
    tbl[1]  = '{1, 0, 0, 1, 0, 1};
    tbl[2]  = '{1, 0, 0, 1, 0, 1};
    tbl[3]  = '{1, 0, 0, 1, 0, 1};
    tbl[4]  = '{1, 0, 0, 1, 0, 1};
    tbl[5]  = '{1, 0, 0, 0, 0, 1};
    tbl[6]  = '{1, 0, 0, 0, 0, 1};
    tbl[7]  = '{1, 0, 0, 0, 0, 1};
    tbl[8]  = '{1, 0, 0, 0, 0, 1};
    tbl[9]  = '{1, 0, 0, 1, 0, 1};
    tbl[10] = '{0, 0, 0, 1, 0, 1};
    tbl[11] = '{0, 0, 0, 1, 0, 1};
    tbl[12] = '{0, 0, 0, 1, 0, 1};
    tbl[13] = '{0, 0, 0, 0, 0, 1};
    tbl[14] = '{0, 0, 0, 0, 0, 1};
    tbl[15] = '{0, 0, 0, 0, 0, 1};
    tbl[16] = '{0, 0, 0, 0, 0, 1};
    tbl[17] = '{0, 0, 0, 0, 0, 0};
    tbl[18] = '{0, 0, 0, 0, 0, 0};

    rst_n = 1'b0; en = 1'b0; div = 4'd0; div_ld = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_z", z, 0);
    chk("rst_ack", div_ack, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ratio 2 after reset: Z toggles every edge, first rise one edge after EN.
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0);
      chk("r2_z", z, (i % 2 == 0) ? 1 : 0);
      chk("r2_busy", busy, 1);
    end
    repeat (4) cyc(0, 0, 0);
    chk("r2_stop_z", z, 0);
    chk("r2_stop_busy", busy, 0);

    for (int i = 0; i < 19; i++) begin
      cyc(tbl[i].en, tbl[i].ld, tbl[i].div);
      chk($sformatf("tbl%0d_z", i), z, tbl[i].z);
      chk($sformatf("tbl%0d_ack", i), div_ack, tbl[i].ack);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
    end

    // Ratio 8 running, load 1 mid-HIGH: old period completes, ack on first new rise.
    rises.delete(); prev_z = z;
    for (int i = 1; i <= 13; i++) begin
      cyc(1, i == 2, (i == 2) ? 4'd1 : 4'd0);
      ez = (i <= 4) || (i == 9) || (i == 10) || (i == 13);
      ea = (i == 9);
      chk($sformatf("chg_e%0d_z", i), z, ez);
      chk($sformatf("chg_e%0d_ack", i), div_ack, ea);
      if (z && !prev_z) rises.push_back(i);
      prev_z = z;
    end
    if (rises.size() < 3) begin
      n_chk++; n_fail++;
      $display("FAIL chg_rises: got %0d rising edges, expected 3", rises.size());
    end else begin
      chk("chg_period_old", rises[1] - rises[0], ratio(3));
      chk("chg_period_new", rises[2] - rises[1], ratio(1));
    end
    repeat (6) cyc(0, 0, 0);
    chk("chg_stop_busy", busy, 0);

    // Reset while Z high with a load pending: immediate low, ratio 2, no ack afterwards.
    cyc(0, 1, 3);
    cyc(1, 0, 0);
    cyc(1, 1, 5);
    chk("pre_rst_z", z, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_z", z, 0);
    chk("async_rst_busy", busy, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 0);
      chk("post_rst_z", z, (i % 2 == 0) ? 1 : 0);
      acks += div_ack;
    end
    chk("post_rst_acks", acks, 0);
    repeat (4) cyc(0, 0, 0);

    // Two loads in one period: only the last one lands, single ack.
    cyc(0, 1, 3);
    chk("dbl_pre_ack", div_ack, 1);
    rises.delete(); prev_z = z; acks = 0;
    for (int i = 1; i <= 15; i++) begin
      cyc(1, (i == 2) || (i == 6), (i == 2) ? 4'd5 : ((i == 6) ? 4'd2 : 4'd0));
      ez = (i <= 4) || (i >= 9 && i <= 11) || (i == 15);
      chk($sformatf("dbl_e%0d_z", i), z, ez);
      if (div_ack) begin
        acks++;
        chk("dbl_ack_edge", i, 9);
      end
      if (z && !prev_z) rises.push_back(i);
      prev_z = z;
    end
    chk("dbl_acks", acks, 1);
    if (rises.size() < 3) begin
      n_chk++; n_fail++;
      $display("FAIL dbl_rises: got %0d rising edges, expected 3", rises.size());
    end else begin
      chk("dbl_period_old", rises[1] - rises[0], ratio(3));
      chk("dbl_period_new", rises[2] - rises[1], ratio(2));
    end

    // Random run/stop and loads, checked against the model every edge.
    ren = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) ren = !ren;
      cyc(ren, $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)));
    end
    repeat (40) cyc(0, 0, 0);
    chk("final_idle_busy", busy, 0);
    chk("final_idle_z", z, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
